key_search_ctrl: RTL and testbench



---
 rtl/key_search_ctrl.sv | 135 +++++++++++++
 tb/tb_key_search_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_ctrl.sv
// Key search controller: steps through candidate RC4 keys, resets the
// decryption core once per candidate and stops on the first crack or at the
// end of the key range.
module key_search_ctrl #(
  parameter logic [23:0] KEY_START  = 24'h000000,
  parameter logic [23:0] KEY_END    = 24'h3FFFFF,
  parameter int unsigned KEY_STEP   = 1,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        core_cracked,
  input  logic        core_failed,
  output logic        core_rst,
  output logic [23:0] secret_key,
  output logic        searching,
  output logic        found,
  output logic        exhausted,
  output logic [23:0] attempts
);

  localparam int unsigned KEY_W  = 24;
  localparam int unsigned SUM_W  = KEY_W + 1;
  localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_CORE,
    S_WAIT,
    S_NEXT,
    S_FOUND,
    S_EXHAUSTED
  } state_t;

  state_t             state, state_nx;
  logic [HOLD_W-1:0]  hold_cnt, hold_nx;
  logic [WD_W-1:0]    wd_cnt, wd_nx;
  logic [KEY_W-1:0]   key_nx, att_nx, att_inc;
  logic [SUM_W-1:0]   key_sum;
  logic               core_rst_nx, searching_nx, found_nx, exhausted_nx;

  // One bit wider than the key so a step past 24'hFFFFFF cannot wrap to 0.
  assign key_sum = {1'b0, secret_key} + SUM_W'(KEY_STEP);
  assign att_inc = (attempts == '1) ? attempts : attempts + KEY_W'(1);

  // Next-state, counters, key/attempt updates and registered-output values.
  always_comb begin
    state_nx     = state;
    hold_nx      = hold_cnt;
    wd_nx        = wd_cnt;
    key_nx       = secret_key;
    att_nx       = attempts;
    core_rst_nx  = 1'b1;
    searching_nx = 1'b0;
    found_nx     = 1'b0;
    exhausted_nx = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (go) begin
          state_nx = S_RESET_CORE;
          hold_nx  = '0;
        end
      end
      S_RESET_CORE: begin
        if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
          state_nx = S_WAIT;
          wd_nx    = '0;
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      S_WAIT: begin
        wd_nx = wd_cnt + WD_W'(1);
        if (core_cracked) begin
          state_nx = S_FOUND;
          att_nx   = att_inc;
        end else if (core_failed || (wd_cnt == WD_W'(TIMEOUT - 1))) begin
          state_nx = S_NEXT;
          att_nx   = att_inc;
        end
      end
      S_NEXT: begin
        hold_nx = '0;
        if (key_sum > SUM_W'(KEY_END)) begin
          state_nx = S_EXHAUSTED;
        end else begin
          key_nx   = key_sum[KEY_W-1:0];
          state_nx = S_RESET_CORE;
        end
      end
      S_FOUND, S_EXHAUSTED: begin
        state_nx = state;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Core stays out of reset while running and after a crack so its RAM is readable.
    core_rst_nx  = !((state_nx == S_WAIT) || (state_nx == S_FOUND));
    searching_nx = (state_nx == S_RESET_CORE) || (state_nx == S_WAIT) || (state_nx == S_NEXT);
    found_nx     = (state_nx == S_FOUND);
    exhausted_nx = (state_nx == S_EXHAUSTED);
  end

  // State, counters and all outputs registered with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      wd_cnt     <= '0;
      secret_key <= KEY_START;
      attempts   <= '0;
      core_rst   <= 1'b1;
      searching  <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_nx;
      wd_cnt     <= wd_nx;
      secret_key <= key_nx;
      attempts   <= att_nx;
      core_rst   <= core_rst_nx;
      searching  <= searching_nx;
      found      <= found_nx;
      exhausted  <= exhausted_nx;
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: two instances (mid-range step 1, and top-of-keyspace
// step 2) driven by behavioural core models and checked every cycle against an
// expected-output timeline generated per search from the candidate sequence.
module tb_key_search_ctrl;

  localparam logic [23:0] S0 = 24'h000240;
  localparam logic [23:0] E0 = 24'h00024F;
  localparam logic [23:0] S1 = 24'hFFFFFC;
  localparam logic [23:0] E1 = 24'hFFFFFF;
  localparam int ST0 = 1;
  localparam int ST1 = 2;
  localparam int R0  = 2;
  localparam int R1  = 3;
  localparam int T0  = 100;
  localparam int T1  = 40;

  localparam int M_DIR   = 0;
  localparam int M_RND   = 1;
  localparam int M_NEVER = 2;
  localparam int M_SIM   = 3;

  typedef struct packed {
    logic        crst;
    logic [23:0] key;
    logic        srch;
    logic        fnd;
    logic        exh;
    logic [23:0] att;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go  = 1'b0;
  logic [1:0]  cr  = '0;
  logic [1:0]  fl  = '0;
  logic [1:0]  crst, srch, fnd, exh;
  logic [23:0] key[2];
  logic [23:0] att[2];

  int          n_checks = 0;
  int          n_err    = 0;
  logic        chk_on   = 1'b0;
  int          mode     = M_DIR;
  int unsigned seed     = 0;
  logic [23:0] crack_key[2];
  logic        crack_en[2];

  always #5 clk = ~clk;

  key_search_ctrl #(.KEY_START(S0), .KEY_END(E0), .KEY_STEP(ST0), .RST_CYCLES(R0), .TIMEOUT(T0)) dut0 (
    .clk(clk), .rst(rst), .go(go), .core_cracked(cr[0]), .core_failed(fl[0]),
    .core_rst(crst[0]), .secret_key(key[0]), .searching(srch[0]), .found(fnd[0]),
    .exhausted(exh[0]), .attempts(att[0]));

  key_search_ctrl #(.KEY_START(S1), .KEY_END(E1), .KEY_STEP(ST1), .RST_CYCLES(R1), .TIMEOUT(T1)) dut1 (
    .clk(clk), .rst(rst), .go(go), .core_cracked(cr[1]), .core_failed(fl[1]),
    .core_rst(crst[1]), .secret_key(key[1]), .searching(srch[1]), .found(fnd[1]),
    .exhausted(exh[1]), .attempts(att[1]));

  function automatic logic [24:0] cfg_start(int i);
    return (i == 0) ? {1'b0, S0} : {1'b0, S1};
  endfunction
  function automatic logic [24:0] cfg_end(int i);
    return (i == 0) ? {1'b0, E0} : {1'b0, E1};
  endfunction
  function automatic int cfg_step(int i);
    return (i == 0) ? ST0 : ST1;
  endfunction
  function automatic int cfg_r(int i);
    return (i == 0) ? R0 : R1;
  endfunction
  function automatic int cfg_t(int i);
    return (i == 0) ? T0 : T1;
  endfunction

  // Cycles after core reset release before the core model raises its flag.
  function automatic int delay_of(int i, logic [23:0] k);
    if (mode == M_DIR) return (crack_en[i] && k == crack_key[i]) ? 50 : 30;
    return 1 + int'((32'(k) ^ seed) % 32'd45);
  endfunction

  function automatic exp_t mk(logic e_rst, logic [23:0] e_key, logic e_srch,
                              logic e_fnd, logic e_exh, logic [23:0] e_att);
    exp_t e;
    e.crst = e_rst; e.key = e_key; e.srch = e_srch;
    e.fnd = e_fnd; e.exh = e_exh; e.att = e_att;
    return e;
  endfunction

  // Behavioural decryption cores: flag rises delay_of() cycles after release, held until reset.
  int cnt[2] = '{0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (crst[i] === 1'b1) begin
        cnt[i] <= 0;
        cr[i]  <= 1'b0;
        fl[i]  <= 1'b0;
      end else begin
        cnt[i] <= cnt[i] + 1;
        if (mode != M_NEVER && cnt[i] + 1 == delay_of(i, key[i])) begin
          if (crack_en[i] && key[i] == crack_key[i]) begin
            cr[i] <= 1'b1;
            if (mode == M_SIM) fl[i] <= 1'b1;
          end else begin
            fl[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Reference model: whole expected output timeline of one search, one entry per cycle.
  exp_t tr[2][0:4095];
  int   tlen[2] = '{0, 0};
  int   tidx[2] = '{0, 0};
  exp_t ecur[2];

  task automatic build(int i);
    logic [24:0] k;
    logic [23:0] a;
    int n, d, wl;
    logic hit, done;
    k = cfg_start(i); a = '0; n = 0; done = 1'b0;
    while (!done && n < 3900) begin
      for (int r = 0; r < cfg_r(i); r++) begin tr[i][n] = mk(1'b1, k[23:0], 1'b1, 1'b0, 1'b0, a); n++; end
      if (mode == M_NEVER) begin
        wl = cfg_t(i); hit = 1'b0;
      end else begin
        d   = delay_of(i, k[23:0]);
        wl  = (d + 1 <= cfg_t(i)) ? d + 1 : cfg_t(i);
        hit = (d + 1 <= cfg_t(i)) && crack_en[i] && (k[23:0] == crack_key[i]);
      end
      for (int w = 0; w < wl; w++) begin tr[i][n] = mk(1'b0, k[23:0], 1'b1, 1'b0, 1'b0, a); n++; end
      a = a + 24'd1;
      if (hit) begin
        tr[i][n] = mk(1'b0, k[23:0], 1'b0, 1'b1, 1'b0, a); n++;
        done = 1'b1;
      end else begin
        tr[i][n] = mk(1'b1, k[23:0], 1'b1, 1'b0, 1'b0, a); n++;
        if (k + 25'(cfg_step(i)) > cfg_end(i)) begin
          tr[i][n] = mk(1'b1, k[23:0], 1'b0, 1'b0, 1'b1, a); n++;
          done = 1'b1;
        end else begin
          k = k + 25'(cfg_step(i));
        end
      end
    end
    tlen[i] = n;
    tidx[i] = 0;
  endtask

  // Advance the model on each active edge using the inputs the DUT samples.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ecur[i] = mk(1'b1, cfg_start(i) >> 0 == 25'd0 ? 24'd0 : cfg_start(i)[23:0], 1'b0, 1'b0, 1'b0, 24'd0);
        tlen[i] = 0; tidx[i] = 0;
      end else if (tidx[i] < tlen[i]) begin
        ecur[i] = tr[i][tidx[i]];
        tidx[i]++;
      end else if (!ecur[i].srch && !ecur[i].fnd && !ecur[i].exh && go) begin
        build(i);
        ecur[i] = tr[i][0];
        tidx[i] = 1;
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        exp_t act;
        act = mk(crst[i], key[i], srch[i], fnd[i], exh[i], att[i]);
        n_checks++;
        if (act !== ecur[i]) begin
          n_err++;
          $display("FAIL cycle_cmp dut%0d t=%0t: got rst=%b key=%h srch=%b fnd=%b exh=%b att=%0d; expected rst=%b key=%h srch=%b fnd=%b exh=%b att=%0d",
                   i, $time, act.crst, act.key, act.srch, act.fnd, act.exh, act.att,
                   ecur[i].crst, ecur[i].key, ecur[i].srch, ecur[i].fnd, ecur[i].exh, ecur[i].att);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; go = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic run_to_end(int budget, logic toggle);
    int c;
    c = 0;
    while (!((fnd[0] | exh[0]) && (fnd[1] | exh[1])) && c < budget) begin
      @(negedge clk);
      if (toggle) go = 1'($urandom_range(0, 1));
      c++;
    end
    chk("search_terminates", 32'(c < budget), 32'd1);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lo, c;
    crack_key[0] = 24'h000249; crack_key[1] = 24'h0;
    crack_en[0]  = 1'b1;       crack_en[1]  = 1'b0;
    rst = 1'b1; go = 1'b0;
    tick(3);
    chk_on = 1'b1;
    #1;
    chk("reset_core_rst", 32'(crst[0]), 32'd1);
    chk("reset_key", 32'(key[0]), 32'h000240);
    chk("reset_attempts", 32'(att[0]), 32'd0);
    chk("reset_flags", {29'd0, srch[0], fnd[0], exh[0]}, 32'd0);
    rst = 1'b0;

    // Directed crack mid-range; wrap instance always fails.
    mode = M_DIR;
    pulse_go();
    run_to_end(5000, 1'b0);
    chk("crack_found", 32'(fnd[0]), 32'd1);
    chk("crack_key", 32'(key[0]), 32'h000249);
    chk("crack_attempts", 32'(att[0]), 32'd10);
    chk("crack_core_rst", 32'(crst[0]), 32'd0);
    chk("wrap_exhausted", 32'(exh[1]), 32'd1);
    chk("wrap_last_key", 32'(key[1]), 32'hFFFFFE);
    chk("wrap_attempts", 32'(att[1]), 32'd2);
    chk("wrap_found", 32'(fnd[1]), 32'd0);

    // Exhaustion of the whole range.
    do_reset();
    crack_en[0] = 1'b0;
    pulse_go();
    run_to_end(5000, 1'b0);
    chk("exh_flag", 32'(exh[0]), 32'd1);
    chk("exh_attempts", 32'(att[0]), 32'd16);
    chk("exh_key", 32'(key[0]), 32'h00024F);
    chk("exh_found", 32'(fnd[0]), 32'd0);

    // Watchdog: silent core.
    do_reset();
    mode = M_NEVER;
    pulse_go();
    c = 0;
    while (crst[0] !== 1'b0 && c < 50) begin @(negedge clk); c++; end
    lo = 0;
    while (crst[0] === 1'b0 && lo < 300) begin lo++; @(negedge clk); end
    chk("watchdog_wait_len", 32'(lo), 32'd100);
    run_to_end(6000, 1'b0);
    chk("watchdog_attempts", 32'(att[0]), 32'd16);
    chk("watchdog_exh", 32'(exh[0]), 32'd1);

    // Simultaneous flags with go toggling throughout.
    do_reset();
    mode = M_SIM; seed = $urandom;
    crack_en[0] = 1'b1; crack_en[1] = 1'b1;
    crack_key[0] = S0 + 24'($urandom_range(0, 15));
    crack_key[1] = S1 + 24'(2 * $urandom_range(0, 1));
    go = 1'b1;
    run_to_end(5000, 1'b1);
    for (int k = 0; k < 20; k++) begin @(negedge clk); go = 1'($urandom_range(0, 1)); end
    #1;
    chk("sim_found", 32'(fnd[0]), 32'd1);
    chk("sim_key", 32'(key[0]), 32'(crack_key[0]));
    go = 1'b0;

    // Reset during WAIT on the third candidate, then restart.
    do_reset();
    mode = M_RND; seed = $urandom;
    crack_en[1] = 1'b0;
    crack_key[0] = S0 + 24'd12;
    pulse_go();
    c = 0;
    while (!(key[0] == S0 + 24'd2 && crst[0] === 1'b0) && c < 3000) begin @(negedge clk); c++; end
    chk("third_wait_reached", 32'(c < 3000), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    chk("midrst_core_rst", 32'(crst[0]), 32'd1);
    chk("midrst_key", 32'(key[0]), 32'h000240);
    chk("midrst_attempts", 32'(att[0]), 32'd0);
    chk("midrst_flags", {29'd0, srch[0], fnd[0], exh[0]}, 32'd0);
    @(negedge clk);
    pulse_go();
    run_to_end(5000, 1'b0);
    chk("restart_found", 32'(fnd[0]), 32'd1);
    chk("restart_key", 32'(key[0]), 32'h00024C);
    chk("restart_attempts", 32'(att[0]), 32'd13);

    // Randomized searches.
    for (int r = 0; r < 4; r++) begin
      logic tg;
      do_reset();
      mode = ($urandom_range(0, 1) == 0) ? M_RND : M_SIM;
      seed = $urandom;
      crack_en[0] = 1'($urandom_range(0, 1));
      crack_en[1] = 1'($urandom_range(0, 1));
      crack_key[0] = S0 + 24'($urandom_range(0, 15));
      crack_key[1] = S1 + 24'(2 * $urandom_range(0, 1));
      tg = 1'($urandom_range(0, 1));
      go = 1'b1;
      run_to_end(5000, tg);
      go = 1'b0;
      tick(3);
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
